// File: rtl/csi2_pkg.sv
// CSI-2 shared definitions: data types, unpacker states,
// and RAW10 packing geometry.
package csi2_pkg;

    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_RAW12    = 6'h2C;
    localparam logic [5:0] DT_YUV422_8 = 6'h1E;

    localparam int RAW10_GROUP_BYTES = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SKIP
    } state_t;

    // A RAW10 line must hold a whole, non-empty number of groups
    function automatic logic wc_ok(input logic [15:0] wc);
        return (wc != 16'd0) &&
               ((wc % 16'(RAW10_GROUP_BYTES)) == 16'd0);
    endfunction

endpackage

// File: rtl/csi2_raw10_group_decode.sv
// RAW10 group decode: five payload bytes to four 10-bit pixels.
// Byte 4 carries the two LSBs of each pixel, pixel 0 lowest.
module csi2_raw10_group_decode
    import csi2_pkg::*;
(
    input  logic [RAW10_GROUP_BYTES-1:0][7:0] group_bytes,
    output logic [3:0][9:0]                   group_pixel
);

    // Pair each MSB byte with its 2-bit slice of the LSB byte
    always_comb begin
        group_pixel = '0;
        for (int n = 0; n < 4; n++) begin
            group_pixel[n] = {group_bytes[n],
                              group_bytes[4][2*n +: 2]};
        end
    end

endmodule

// File: rtl/csi2_raw10_unpacker.sv
// RAW10 long-packet unpacker behind the CSI-2 receiver.
// Collects payload bytes and emits 4-pixel groups with line_end.
module csi2_raw10_unpacker
    import csi2_pkg::*;
#(
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
    parameter logic [5:0] DATA_TYPE       = DT_RAW10
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [1:0]      virtual_channel,
    input  logic [15:0]     word_count,
    input  logic [3:0][7:0] image_data,
    input  logic [5:0]      image_data_type,
    input  logic            image_data_enable,
    output logic [3:0][9:0] pixel,
    output logic            pixel_enable,
    output logic            line_end,
    output logic            error
);

    state_t          state_q;
    logic            enable_q;
    logic [15:0]     wc_q;
    logic [15:0]     rcvd_q;
    logic [7:0][7:0] byte_buf_q;
    logic [3:0]      fill_q;

    logic            hdr_match;
    logic            wc_valid;
    logic            start;
    logic            start_ok;
    logic            bad_wc;
    logic            append;
    logic            trunc;
    logic            emit;
    logic            last_group;
    logic [3:0]      base_fill;
    logic [3:0]      new_fill;
    logic [15:0]     base_rcvd;
    logic [15:0]     cur_wc;
    logic [15:0]     remaining;
    logic [15:0]     new_rcvd;
    logic [2:0]      take;
    logic [7:0][7:0] merged;
    logic [7:0][7:0] shifted;
    logic [3:0][9:0] group_pixel;

    assign hdr_match = (virtual_channel == VIRTUAL_CHANNEL) &&
                       (image_data_type == DATA_TYPE);
    assign wc_valid  = wc_ok(word_count);

    // enable_q resets high so a packet already in flight at
    // reset release is not mistaken for a fresh rising edge.
    assign start    = (state_q == IDLE) && image_data_enable &&
                      !enable_q;
    assign start_ok = start && hdr_match && wc_valid;
    assign bad_wc   = start && hdr_match && !wc_valid;

    assign append = start_ok ||
                    ((state_q == ACTIVE) && image_data_enable);
    assign trunc  = (state_q == ACTIVE) && !image_data_enable &&
                    (rcvd_q != wc_q);

    assign base_fill = start_ok ? 4'd0 : fill_q;
    assign base_rcvd = start_ok ? 16'd0 : rcvd_q;
    assign cur_wc    = start_ok ? word_count : wc_q;
    assign remaining = cur_wc - base_rcvd;

    assign take = !append               ? 3'd0 :
                  (remaining >= 16'd4)  ? 3'd4 :
                                          remaining[2:0];

    assign new_fill   = base_fill + {1'b0, take};
    assign new_rcvd   = base_rcvd + {13'd0, take};
    assign emit       = new_fill >= 4'(RAW10_GROUP_BYTES);
    assign last_group = emit && (new_rcvd == cur_wc);
    assign shifted    = merged >> (8 * RAW10_GROUP_BYTES);

    // Append this beat's accepted bytes behind the buffered ones
    always_comb begin
        merged = start_ok ? '0 : byte_buf_q;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < take) begin
                merged[3'(base_fill) + 3'(k)] = image_data[k];
            end
        end
    end

    csi2_raw10_group_decode u_decode (
        .group_bytes (merged[4:0]),
        .group_pixel (group_pixel)
    );

    // Packet state: qualify the header on each enable rising edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            enable_q <= 1'b1;
            wc_q     <= '0;
        end else begin
            enable_q <= image_data_enable;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= start_ok ? ACTIVE : SKIP;
                        wc_q    <= word_count;
                    end
                end
                ACTIVE, SKIP: begin
                    if (!image_data_enable) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte buffer and counter; flushed whenever enable is low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_buf_q <= '0;
            fill_q     <= '0;
            rcvd_q     <= '0;
        end else if (append) begin
            byte_buf_q <= emit ? shifted : merged;
            fill_q     <= emit ?
                          new_fill - 4'(RAW10_GROUP_BYTES) :
                          new_fill;
            rcvd_q     <= new_rcvd;
        end else if (!image_data_enable) begin
            byte_buf_q <= '0;
            fill_q     <= '0;
            rcvd_q     <= '0;
        end
    end

    // Registered pixel group, line marker and error pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel        <= '0;
            pixel_enable <= 1'b0;
            line_end     <= 1'b0;
            error        <= 1'b0;
        end else begin
            pixel_enable <= emit;
            line_end     <= last_group;
            error        <= bad_wc || trunc;
            if (emit) pixel <= group_pixel;
        end
    end

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Scoreboard bench for csi2_raw10_unpacker.
// Stimulus pushes expected groups/errors; a monitor pops them.
module tb_csi2_raw10_unpacker;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [1:0]      virtual_channel;
    logic [15:0]     word_count;
    logic [3:0][7:0] image_data;
    logic [5:0]      image_data_type;
    logic            image_data_enable;
    logic [3:0][9:0] pixel;
    logic            pixel_enable;
    logic            line_end;
    logic            error;

    always #5 clock = ~clock;

    csi2_raw10_unpacker dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .virtual_channel   (virtual_channel),
        .word_count        (word_count),
        .image_data        (image_data),
        .image_data_type   (image_data_type),
        .image_data_enable (image_data_enable),
        .pixel             (pixel),
        .pixel_enable      (pixel_enable),
        .line_end          (line_end),
        .error             (error)
    );

    typedef struct {
        logic [39:0] px;
        logic        le;
        int          cyc;
    } exp_t;

    exp_t gq[$];
    int   eq[$];
    exp_t mon_e;
    int   mon_c;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Payload 0x00..0x13 and its hand-decoded groups
    logic [31:0] p20 [5];
    logic [39:0] g20 [4];
    logic [39:0] g5;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every presented group / error pulse
    always @(negedge clock) begin
        if (reset_n) begin
            if (pixel_enable) begin
                n_checks++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_group: got pixel=%h le=%b cyc=%0d, required none",
                             pixel, line_end, cyc);
                end else begin
                    mon_e = gq.pop_front();
                    if (pixel !== mon_e.px || line_end !== mon_e.le ||
                        cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL group: got pixel=%h le=%b cyc=%0d, required pixel=%h le=%b cyc=%0d",
                                 pixel, line_end, cyc,
                                 mon_e.px, mon_e.le, mon_e.cyc);
                    end
                end
            end else if (line_end !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lone_line_end: got line_end=%b cyc=%0d, required 0",
                         line_end, cyc);
            end
            if (error) begin
                n_checks++;
                if (eq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_error: got error=1 cyc=%0d, required 0",
                             cyc);
                end else begin
                    mon_c = eq.pop_front();
                    if (cyc != mon_c) begin
                        n_fail++;
                        $display("FAIL error_cycle: got cyc=%0d, required cyc=%0d",
                                 cyc, mon_c);
                    end
                end
            end
        end
    end

    task automatic hdr(input logic [1:0] vc, input logic [5:0] dt,
                       input logic [15:0] wc);
        virtual_channel = vc;
        image_data_type = dt;
        word_count      = wc;
    endtask

    task automatic beat(input logic [31:0] d);
        @(posedge clock);
        #1;
        image_data        = d;
        image_data_enable = 1'b1;
        last_cyc          = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            image_data_enable = 1'b0;
            last_cyc          = cyc;
        end
    endtask

    task automatic exp_grp(input logic [39:0] px, input logic le);
        exp_t e;
        e.px  = px;
        e.le  = le;
        e.cyc = last_cyc + 1;
        gq.push_back(e);
    endtask

    task automatic drain(input string name);
        gap(4);
        n_checks++;
        if (gq.size() != 0 || eq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d groups %0d errors pending, required 0 0",
                     name, gq.size(), eq.size());
        end
        gq.delete();
        eq.delete();
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({pixel, pixel_enable, line_end, error} !== 43'd0) begin
            n_fail++;
            $display("FAIL %s: got pixel=%h pe=%b le=%b err=%b, required all 0",
                     name, pixel, pixel_enable, line_end, error);
        end
    endtask

    task automatic send20(input logic [5:0] dt, input logic [1:0] vc,
                          input logic expect_out);
        hdr(vc, dt, 16'd20);
        for (int i = 0; i < 5; i++) begin
            beat(p20[i]);
            if (expect_out && i > 0) exp_grp(g20[i-1], i == 4);
        end
    endtask

    task automatic send5();
        hdr(2'd0, 6'h2B, 16'd5);
        beat(32'h78563412);
        beat(32'hAABBCCE4);
        exp_grp(g5, 1'b1);
    endtask

    initial begin
        p20[0] = 32'h03020100;
        p20[1] = 32'h07060504;
        p20[2] = 32'h0B0A0908;
        p20[3] = 32'h0F0E0D0C;
        p20[4] = 32'h13121110;
        g20[0] = {10'h00C, 10'h008, 10'h005, 10'h000};
        g20[1] = {10'h020, 10'h01C, 10'h01A, 10'h015};
        g20[2] = {10'h034, 10'h030, 10'h02F, 10'h02A};
        g20[3] = {10'h048, 10'h045, 10'h040, 10'h03F};
        g5     = {10'h1E3, 10'h15A, 10'h0D1, 10'h048};

        reset_n           = 1'b0;
        image_data_enable = 1'b0;
        image_data        = '0;
        hdr(2'd0, 6'h2B, 16'd0);
        #1;
        check_zero("reset_state");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        gap(2);

        send5();
        drain("wc5");

        send20(6'h2B, 2'd0, 1'b1);
        drain("wc20");

        send20(6'h2A, 2'd0, 1'b0);
        drain("raw8_ignored");

        send20(6'h2B, 2'd1, 1'b0);
        drain("vc1_ignored");

        hdr(2'd0, 6'h2B, 16'd7);
        beat(p20[0]);
        eq.push_back(last_cyc + 1);
        beat(p20[1]);
        drain("wc7");

        hdr(2'd0, 6'h2B, 16'd20);
        beat(p20[0]);
        beat(p20[1]);
        exp_grp(g20[0], 1'b0);
        beat(p20[2]);
        exp_grp(g20[1], 1'b0);
        gap(1);
        eq.push_back(last_cyc + 1);
        send5();
        drain("truncate");

        hdr(2'd0, 6'h2B, 16'd20);
        beat(p20[0]);
        beat(p20[1]);
        @(posedge clock);
        #1;
        reset_n           = 1'b0;
        image_data_enable = 1'b0;
        #1;
        check_zero("mid_reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        gap(2);
        send5();
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csi2_raw10_unpacker.md
Name: csi2_raw10_unpacker

Overview:
- Sits directly downstream of the CSI-2 `camera` receiver.
- Consumes its 4-byte-per-beat long-packet payload stream (image_data, image_data_enable, image_data_type, word_count, virtual_channel).
- Unpacks RAW10 (data type 0x2B) payload, where 5 bytes carry 4 pixels, into 4×10-bit pixel groups with a line_end marker.
- Packets with any other data type or virtual channel are ignored.

Parameters:
- VIRTUAL_CHANNEL, 2'd0, only packets on this channel are unpacked.
- DATA_TYPE, 6'h2B, CSI-2 data type accepted (RAW10).

Ports:
- clock  input  1  pixel-side byte clock, same domain as the receiver outputs.
- reset_n  input  1  asynchronous, active-low reset.
- virtual_channel  input  2  channel of the current packet.
- word_count  input  16  payload byte count of the current packet.
- image_data  input  8×4 (logic [7:0] [3:0])  payload beat; image_data[0] is the earliest byte.
- image_data_type  input  6  data type of the current packet.
- image_data_enable  input  1  beat valid; high continuously for one packet's payload.
- pixel  output  10×4 (logic [9:0] [3:0])  unpacked pixels; pixel[0] is leftmost.
- pixel_enable  output  1  pixel group valid.
- line_end  output  1  asserted together with the last pixel group of a packet.
- error  output  1  one-cycle pulse on a bad packet (see below).

Behaviour:
- Reset:
  - pixel = 0, pixel_enable = 0, line_end = 0, error = 0.
  - Byte buffer emptied, byte counter = 0, state IDLE.
- States:
  - IDLE -> ACTIVE on a rising edge of image_data_enable when virtual_channel == VIRTUAL_CHANNEL and image_data_type == DATA_TYPE.
  - IDLE -> SKIP on a rising edge when either does not match.
  - ACTIVE/SKIP -> IDLE when image_data_enable is low.
- Packet start:
  - On entry to ACTIVE, the buffer and byte counter clear.
  - word_count is latched. If latched word_count is 0 or not a multiple of 5, pulse error and go to SKIP.
- Buffer:
  - 8-byte shift buffer with fill count 0..8.
  - Each ACTIVE beat appends min(4, word_count − bytes_received) bytes, in image_data[0..3] order.
  - Bytes beyond word_count in the final beat are discarded.
- Emit rule:
  - If fill ≥ 5 after an append, the oldest 5 bytes B0..B4 form one group and fill decreases by 5.
  - Pre-append fill is ≤ 4, so at most one group is emitted per cycle and no backpressure is needed.
- Pixel formula: pixel[n] = {Bn, B4[2n+1:2n]} for n = 0..3.
- Latency: the group is registered; pixel_enable is high the cycle after the beat that completes the fifth byte. pixel holds its last value when pixel_enable = 0.
- line_end is high with the group whose final byte makes bytes_received == word_count. Return to IDLE then happens when enable drops.
- Truncation: if image_data_enable falls in ACTIVE with bytes_received < word_count:
  - error pulses the cycle after the falling edge;
  - the buffer is flushed and no partial group is emitted;
  - line_end is not asserted.
- Overrun: extra beats after word_count is reached are ignored until enable falls.
- Back-to-back packets: a falling then rising edge of image_data_enable starts a fresh packet; state never carries over.
- Mid-operation reset: outputs return to reset values asynchronously; the partial packet is lost and the next rising edge of enable is treated as a new packet.
- Byte counter is 16-bit and saturates at word_count (never wraps).

Decomposition:
- Shared package csi2_pkg:
  - data type constants (RAW8 = 6'h2A, RAW10 = 6'h2B, RAW12 = 6'h2C, YUV422_8 = 6'h1E);
  - state enum typedef {IDLE, ACTIVE, SKIP};
  - RAW10_GROUP_BYTES = 5.
- One natural sub-module: csi2_raw10_group_decode, a purely combinational 5 bytes -> 4×10-bit mapping, reusable by a future RAW10 transmitter checker.

Test Plan:
- word_count = 5, single beat {0x78,0x56,0x34,0x12} then beat {x,x,x,0xE4}, type 0x2B, VC 0 -> one group: pixel = {0x1E3,0x15A,0x0D1,0x048}, pixel_enable and line_end high together one cycle after the second beat.
- word_count = 20, 5 beats of bytes 0x00..0x13 -> exactly 4 groups on beats 2, 3, 4, 5 (+1 cycle latency); the first group is pixel[0] = {0x00, 0x04[1:0]} = 0x000; line_end only on the 4th group.
- Same payload with image_data_type = 0x2A, or VC = 1 -> pixel_enable, line_end and error stay 0 throughout.
- word_count = 7 -> error pulses once at packet start; no pixel_enable for the packet.
- word_count = 20, enable dropped after 3 beats -> 2 groups emitted, error pulses the cycle after the drop, no line_end; an immediate following valid 5-byte packet decodes correctly.
- reset_n asserted mid-packet after 2 beats -> outputs 0 immediately; the next packet's first group is correct with no stale bytes.
